// File: rtl/core_pkg.sv
// Core-wide shared types and helpers.
// Opcode map, fetch entry bundle, reset vector.
package core_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_valid_opcode(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM,
      OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR,
      OPC_JAL, OPC_SYSTEM: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries.
// Pushes become visible the cycle after; flush wins.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output fetch_entry_t             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != FULL) | do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// In-order instruction fetch unit.
// Credit-limited requests, in-order responses, redirect flush.
module inst_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  output logic        inst_illegal_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   tgt;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          pend_q, pend_d;
  logic          hold_q, hold_d;
  logic          gnt, rsp, drop, pop;
  logic [CW:0]   occ;

  fetch_entry_t  ibuf_in, ibuf_out;
  fetch_entry_t  pcq_in, pcq_out;
  logic          ibuf_valid, pcq_valid;
  logic [CW-1:0] ibuf_cnt, pcq_cnt;
  logic          unused_ok;

  assign tgt  = {redirect_pc_i[31:2], 2'b00};
  assign pop  = ibuf_valid & inst_ready_i;
  assign rsp  = imem_rvalid_i & (out_cnt_q != '0);
  assign drop = rsp & (drop_cnt_q != '0);
  assign gnt  = imem_req_o & imem_gnt_i;

  // A slot freed by this cycle's pop is reusable at once.
  assign occ = {1'b0, out_cnt_q} + {1'b0, ibuf_cnt}
             - {{CW{1'b0}}, pop};

  assign imem_req_o  = rst_ni & (hold_q | (occ < CAP));
  assign imem_addr_o = fetch_pc_q;

  // Next-state for PC, counters and held redirect.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    out_cnt_d  = out_cnt_q + CW'(gnt) - CW'(rsp);
    drop_cnt_d = drop_cnt_q;
    hold_d     = imem_req_o & ~imem_gnt_i;
    if (drop) drop_cnt_d = drop_cnt_d - CW'(1);
    if (gnt) begin
      if (pend_q) begin
        fetch_pc_d = pend_pc_q;
        pend_d     = 1'b0;
        drop_cnt_d = drop_cnt_d + CW'(1);
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
    if (redirect_i) begin
      drop_cnt_d = out_cnt_d;
      if (hold_d) begin
        pend_d    = 1'b1;
        pend_pc_d = tgt;
      end else begin
        fetch_pc_d = tgt;
        pend_d     = 1'b0;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= '0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pend_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
    end
  end

  assign pcq_in  = '{pc: fetch_pc_q, inst: '0, err: 1'b0};
  assign ibuf_in = '{pc: pcq_out.pc, inst: imem_rdata_i,
                     err: imem_err_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .push_i  (gnt),
    .data_i  (pcq_in),
    .pop_i   (rsp),
    .valid_o (pcq_valid),
    .data_o  (pcq_out),
    .count_o (pcq_cnt)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (rsp & ~drop),
    .data_i  (ibuf_in),
    .pop_i   (pop),
    .valid_o (ibuf_valid),
    .data_o  (ibuf_out),
    .count_o (ibuf_cnt)
  );

  assign inst_valid_o   = ibuf_valid;
  assign inst_o         = ibuf_out.inst;
  assign inst_pc_o      = ibuf_out.pc;
  assign inst_err_o     = ibuf_out.err;
  assign inst_illegal_o = ibuf_valid & ~ibuf_out.err
                        & ~is_valid_opcode(ibuf_out.inst[6:0]);

  assign unused_ok = ^{redirect_pc_i[1:0], pcq_out.inst,
                       pcq_out.err, pcq_valid, pcq_cnt};

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic.
// Reference is the architectural PC stream, not the pipeline.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        imem_err_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;
  logic        inst_illegal_o;

  inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_gnt_i     (imem_gnt_i),
    .imem_rvalid_i  (imem_rvalid_i),
    .imem_rdata_i   (imem_rdata_i),
    .imem_err_i     (imem_err_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_err_o     (inst_err_o),
    .inst_illegal_o (inst_illegal_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] err_addr = 32'h0000_0001;
  logic [31:0] prev_addr = '0;
  logic        hold_prev = 1'b0;
  logic        redir_prev = 1'b0;
  int gnt_p = 100, rsp_p = 100, rdy_p = 100;
  bit rnd_redir = 0, stray = 0, redir = 0;
  logic [31:0] redir_pc = '0;
  int gcount = 0, hs_cnt = 0;
  bit seen4 = 0;
  logic err4 = 1'b0, ill4 = 1'b0;
  logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23,
                           7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h308) return 32'h0000_007F;
    if (a < 32'h1000) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  function automatic logic errf(input logic [31:0] a);
    return (a == err_addr) || (a >= 32'h1000 && a[6:2] == 5'h1F);
  endfunction

  function automatic logic legal(input logic [6:0] op);
    foreach (ops[i]) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [31:0] w;
    logic        e;
    @(negedge clk);
    imem_gnt_i   = ($urandom_range(99) < gnt_p);
    inst_ready_i = ($urandom_range(99) < rdy_p);
    if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      imem_err_i    = 1'b1;
    end else if (mq.size() > 0 && $urandom_range(99) < rsp_p) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = word(mq[0]);
      imem_err_i    = errf(mq[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      imem_err_i    = 1'($urandom_range(1));
    end
    if (rnd_redir) begin
      redirect_i = ($urandom_range(99) < 6);
      redirect_pc_i = ($urandom_range(1) == 1) ? 32'($urandom)
                    : 32'h1000 + 32'($urandom_range(255)) * 4
                      + 32'($urandom_range(3));
    end else begin
      redirect_i    = redir;
      redirect_pc_i = redir_pc;
    end
    #1;
    if (hold_prev) begin
      check("req_stable", imem_req_o, 1);
      check("addr_stable", imem_addr_o, prev_addr);
    end
    if (redir_prev) check("valid_after_redirect", inst_valid_o, 0);
    if (inst_valid_o && inst_ready_i) begin
      w = word(exp_pc);
      e = errf(exp_pc);
      check("hs_pc", inst_pc_o, exp_pc);
      check("hs_inst", inst_o, w);
      check("hs_err", inst_err_o, e);
      check("hs_illegal", inst_illegal_o, !e && !legal(w[6:0]));
      if (exp_pc == 32'h4) begin
        seen4 = 1;
        err4  = inst_err_o;
        ill4  = inst_illegal_o;
      end
      exp_pc += 32'd4;
      hs_cnt++;
    end
    if (redirect_i) exp_pc = redirect_pc_i & ~32'd3;
    if (imem_rvalid_i && !stray) void'(mq.pop_front());
    if (imem_req_o && imem_gnt_i) begin
      mq.push_back(imem_addr_o);
      gcount++;
    end
    check("outstanding_cap", mq.size() <= DEPTH, 1);
    hold_prev  = imem_req_o && !imem_gnt_i;
    prev_addr  = imem_addr_o;
    redir_prev = redirect_i;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    #1;
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, RST_PC);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", inst_pc_o, 0);
    check("rst_err", inst_err_o, 0);
    check("rst_illegal", inst_illegal_o, 0);
    mq.delete();
    exp_pc = RST_PC;
    hold_prev = 1'b0;
    redir_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (inst_valid_o) break;
    end
    check(tag, inst_valid_o, 1);
  endtask

  initial begin
    // A: streaming from reset with zero-wait memory
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc();
      check("A_valid", inst_valid_o, (i >= 3) ? 1 : 0);
      check("A_req", imem_req_o, 1);
      if (i <= 4) check("A_addr", imem_addr_o, 32'(4 * (i - 1)));
    end

    // B: consumer stalled, credit caps grants
    do_reset();
    rdy_p = 0;
    gcount = 0;
    repeat (10) cyc();
    check("B_grants", gcount, DEPTH);
    check("B_req_low", imem_req_o, 0);
    rdy_p = 100;
    hs_cnt = 0;
    repeat (10) cyc();
    check("B_progress", hs_cnt >= 4, 1);

    // C: redirect with two responses outstanding
    do_reset();
    rsp_p = 0;
    repeat (2) cyc();
    cyc();
    check("C_req_credit", imem_req_o, 0);
    redir = 1;
    redir_pc = 32'h100;
    cyc();
    redir = 0;
    cyc();
    check("C_addr", imem_addr_o, 32'h100);
    rsp_p = 100;
    wait_valid("C_valid_seen");
    check("C_pc", inst_pc_o, 32'h100);
    repeat (5) cyc();

    // D: redirect while request to 0x8 is held ungranted
    do_reset();
    repeat (2) cyc();
    gnt_p = 0;
    cyc();
    check("D_req1", imem_req_o, 1);
    check("D_addr1", imem_addr_o, 32'h8);
    redir = 1;
    redir_pc = 32'h100;
    cyc();
    redir = 0;
    check("D_addr2", imem_addr_o, 32'h8);
    cyc();
    check("D_addr3", imem_addr_o, 32'h8);
    gnt_p = 100;
    cyc();
    cyc();
    check("D_req_next", imem_req_o, 1);
    check("D_addr_next", imem_addr_o, 32'h100);
    wait_valid("D_valid_seen");
    check("D_pc", inst_pc_o, 32'h100);
    repeat (4) cyc();

    // E: bus error at 0x4, illegal opcode at 0x308
    err_addr = 32'h4;
    seen4 = 0;
    do_reset();
    repeat (12) cyc();
    check("E_seen4", seen4, 1);
    check("E_err4", err4, 1);
    check("E_ill4", ill4, 0);
    redir = 1;
    redir_pc = 32'h309;
    cyc();
    redir = 0;
    wait_valid("E_valid_seen");
    check("E_pc", inst_pc_o, 32'h308);
    check("E_inst", inst_o, 32'h7F);
    check("E_illegal", inst_illegal_o, 1);
    repeat (4) cyc();

    // F: address wrap, then reset mid-stream
    redir = 1;
    redir_pc = 32'hFFFF_FFFE;
    cyc();
    redir = 0;
    cyc();
    check("F_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (imem_req_o && imem_addr_o != 32'hFFFF_FFFC) break;
    end
    check("F_addr_wrap", imem_addr_o, 32'h0);
    repeat (6) cyc();
    rsp_p = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (mq.size() >= 2) break;
    end
    check("F_two_out", mq.size(), 2);
    do_reset();
    gnt_p = 0;
    stray = 1;
    cyc();
    stray = 0;
    check("F_restart_req", imem_req_o, 1);
    check("F_restart_addr", imem_addr_o, RST_PC);
    gnt_p = 100;
    rsp_p = 100;
    wait_valid("F_valid_seen");
    check("F_pc", inst_pc_o, RST_PC);
    repeat (4) cyc();

    // R: random traffic against the stream model
    gnt_p = 70;
    rsp_p = 70;
    rdy_p = 75;
    rnd_redir = 1;
    repeat (500) cyc();
    rnd_redir = 0;
    gnt_p = 100;
    rsp_p = 100;
    rdy_p = 100;
    repeat (30) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
